// File: rtl/radio_capture_pkg.sv
// Shared types and constants for the radio RX burst capture engine.
package radio_capture_pkg;
  localparam int CNT_W   = 32;
  localparam int PKT_W   = 16;
  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WAIT_TIME = 2'd1;
  localparam state_t ST_RUNNING   = 2'd2;

  typedef struct packed {
    logic last;
    logic eob;
  } entry_flags_t;
endpackage

// File: rtl/radio_rx_burst_capture_if.sv
// Per-channel AXI-Stream output bundle of the capture engine.
interface radio_rx_burst_capture_if #(
  parameter int NUM_CHANNELS = 1,
  parameter int NSPC         = 1,
  parameter int SAMP_W       = 32,
  parameter int TIME_W       = 64
);
  logic [NUM_CHANNELS*NSPC*SAMP_W-1:0] m_tdata;
  logic [NUM_CHANNELS*TIME_W-1:0]      m_ttimestamp;
  logic [NUM_CHANNELS-1:0]             m_tlast;
  logic [NUM_CHANNELS-1:0]             m_teob;
  logic [NUM_CHANNELS-1:0]             m_tvalid;
  logic [NUM_CHANNELS-1:0]             m_tready;

  modport master (output m_tdata, m_ttimestamp, m_tlast, m_teob, m_tvalid, input m_tready);
  modport slave  (input m_tdata, m_ttimestamp, m_tlast, m_teob, m_tvalid, output m_tready);
endinterface

// File: rtl/radio_rx_capture_fifo.sv
// Single-clock first-word-fall-through FIFO reporting its free-entry count.
module radio_rx_capture_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  input  logic                  rd_en,
  output logic [DEPTH_LOG2:0]   free
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_wr, do_rd;

  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_en && (count != FULL);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (count != '0);
  assign free     = FULL - count;
endmodule

// File: rtl/radio_rx_burst_capture.sv
// RX burst capture: timed/immediate commands, SPP packetisation with per-packet
// timestamps, late and overrun detection, one FWFT FIFO per channel.
module radio_rx_burst_capture
  import radio_capture_pkg::*;
#(
  parameter int SAMP_W         = 32,
  parameter int NSPC           = 1,
  parameter int NUM_CHANNELS   = 1,
  parameter int TIME_W         = 64,
  parameter int FIFO_SIZE_LOG2 = 5
) (
  input  logic                                radio_clk,
  input  logic                                radio_rst,
  input  logic [NUM_CHANNELS*NSPC*SAMP_W-1:0] radio_rx_data,
  input  logic                                radio_rx_stb,
  input  logic [TIME_W-1:0]                   radio_time,
  input  logic [PKT_W-1:0]                    cfg_spp_words,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [CNT_W-1:0]                    cmd_num_words,
  input  logic                                cmd_timed,
  input  logic [TIME_W-1:0]                   cmd_time,
  input  logic                                cmd_stop,
  radio_rx_burst_capture_if.master            rx_stream,
  output logic                                running,
  output logic                                overrun,
  output logic                                late
);
  localparam int CH_W = NSPC * SAMP_W;

  typedef struct packed {
    logic [CH_W-1:0]   data;
    logic [TIME_W-1:0] timestamp;
    entry_flags_t      flags;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);

  logic [NUM_CHANNELS*CH_W-1:0] data_p0;
  logic [TIME_W-1:0]            time_p0;
  logic                         vld_p0;

  state_t            state;
  logic [PKT_W-1:0]  spp, pkt_cnt;
  logic [CNT_W-1:0]  remaining;
  logic              continuous, stop_pend, first_in_pkt, seen_stb;
  logic [TIME_W-1:0] tgt_time, pkt_ts, word_ts;

  logic [NUM_CHANNELS-1:0] nearly_full, full;
  logic is_late, start_now, capture, wr_word, ovf_word, any_full;
  logic burst_end, pkt_end, term;

  logic [NUM_CHANNELS*CH_W-1:0]   tdata_v;
  logic [NUM_CHANNELS*TIME_W-1:0] tts_v;
  logic [NUM_CHANNELS-1:0]        tlast_v, teob_v, tvalid_v;

  // Stage p0: input register; all decisions act on the registered word
  always_ff @(posedge radio_clk) begin
    data_p0 <= radio_rx_data;
    time_p0 <= radio_time;
  end

  // Only the first strobe after accept can be late; later ones just wait for cmd_time
  assign is_late   = (state == ST_WAIT_TIME) && vld_p0 && !seen_stb && (time_p0 > tgt_time);
  assign start_now = (state == ST_WAIT_TIME) && vld_p0 && !cmd_stop && !is_late &&
                     (time_p0 >= tgt_time);
  assign capture   = vld_p0 && ((state == ST_RUNNING) || start_now);
  assign any_full  = |full;
  assign ovf_word  = |nearly_full;
  assign wr_word   = capture && !any_full;
  assign burst_end = !continuous && (remaining == 32'd1);
  assign pkt_end   = (pkt_cnt == spp - 16'd1);
  assign term      = burst_end || stop_pend || ovf_word;
  assign word_ts   = first_in_pkt ? time_p0 : pkt_ts;

  always_ff @(posedge radio_clk) begin
    if ((state == ST_IDLE) && cmd_valid) tgt_time <= cmd_time;
    if (wr_word && first_in_pkt) pkt_ts <= time_p0;
  end

  always_ff @(posedge radio_clk) begin
    if (radio_rst) begin
      vld_p0       <= 1'b0;
      state        <= ST_IDLE;
      spp          <= 16'd1;
      pkt_cnt      <= '0;
      remaining    <= '0;
      continuous   <= 1'b0;
      stop_pend    <= 1'b0;
      first_in_pkt <= 1'b1;
      seen_stb     <= 1'b0;
      overrun      <= 1'b0;
      late         <= 1'b0;
    end else begin
      vld_p0  <= radio_rx_stb;
      overrun <= 1'b0;
      late    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state        <= cmd_timed ? ST_WAIT_TIME : ST_RUNNING;
            spp          <= (cfg_spp_words == '0) ? 16'd1 : cfg_spp_words;
            remaining    <= cmd_num_words;
            continuous   <= (cmd_num_words == '0);
            pkt_cnt      <= '0;
            stop_pend    <= 1'b0;
            first_in_pkt <= 1'b1;
            seen_stb     <= 1'b0;
          end
        end
        ST_WAIT_TIME: begin
          if (cmd_stop) begin
            state <= ST_IDLE;
          end else if (is_late) begin
            late  <= 1'b1;
            state <= ST_IDLE;
          end else if (vld_p0) begin
            seen_stb <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (cmd_stop) stop_pend <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      // A terminating word clears stop_pend, so a coincident stop adds no second EOB
      if (capture) begin
        if (wr_word) begin
          remaining    <= remaining - 32'd1;
          pkt_cnt      <= (pkt_end || term) ? '0 : pkt_cnt + 16'd1;
          first_in_pkt <= pkt_end || term;
        end
        if (term || any_full) begin
          state     <= ST_IDLE;
          stop_pend <= 1'b0;
          overrun   <= ovf_word || any_full;
        end else begin
          state <= ST_RUNNING;
        end
      end
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign running   = (state == ST_WAIT_TIME) || (state == ST_RUNNING);

  // Stage p1: per-channel FWFT FIFOs drive the output streams
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    entry_t                  wr_entry, rd_entry;
    logic [FIFO_SIZE_LOG2:0] free;

    assign wr_entry.data       = data_p0[c*CH_W +: CH_W];
    assign wr_entry.timestamp  = word_ts;
    assign wr_entry.flags.last = pkt_end || term;
    assign wr_entry.flags.eob  = term;

    radio_rx_capture_fifo #(
      .WIDTH      (ENTRY_W),
      .DEPTH_LOG2 (FIFO_SIZE_LOG2)
    ) u_fifo (
      .clk      (radio_clk),
      .rst      (radio_rst),
      .wr_data  (wr_entry),
      .wr_en    (wr_word),
      .rd_data  (rd_entry),
      .rd_valid (tvalid_v[c]),
      .rd_en    (rx_stream.m_tready[c]),
      .free     (free)
    );

    assign nearly_full[c]               = (free == (FIFO_SIZE_LOG2+1)'(1));
    assign full[c]                      = (free == '0);
    assign tdata_v[c*CH_W +: CH_W]      = rd_entry.data;
    assign tts_v[c*TIME_W +: TIME_W]    = rd_entry.timestamp;
    assign tlast_v[c]                   = rd_entry.flags.last;
    assign teob_v[c]                    = rd_entry.flags.eob;
  end

  assign rx_stream.m_tdata      = tdata_v;
  assign rx_stream.m_ttimestamp = tts_v;
  assign rx_stream.m_tlast      = tlast_v;
  assign rx_stream.m_teob       = teob_v;
  assign rx_stream.m_tvalid     = tvalid_v;
endmodule

// File: tb/tb_radio_rx_burst_capture.sv
// Directed bench for radio_rx_burst_capture (2 channels, 2 samples/cycle, 4-deep FIFOs).
module tb_radio_rx_burst_capture;
  localparam int SAMP_W = 32;
  localparam int NSPC   = 2;
  localparam int NCH    = 2;
  localparam int TIME_W = 64;
  localparam int FLOG2  = 2;
  localparam int CH_W   = NSPC * SAMP_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NCH*CH_W-1:0]    rx_data = '0;
  logic                   rx_stb = 1'b0;
  logic [TIME_W-1:0]      rx_time = '0;
  logic [15:0]            spp = 16'd4;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [31:0]            cmd_num = '0;
  logic                   cmd_timed = 1'b0;
  logic [TIME_W-1:0]      cmd_time = '0;
  logic                   cmd_stop = 1'b0;
  logic                   running, overrun, late;

  int cmp_cnt = 0;
  int err_cnt = 0;

  radio_rx_burst_capture_if #(.NUM_CHANNELS(NCH), .NSPC(NSPC), .SAMP_W(SAMP_W), .TIME_W(TIME_W)) rx_stream();

  radio_rx_burst_capture #(
    .SAMP_W(SAMP_W), .NSPC(NSPC), .NUM_CHANNELS(NCH), .TIME_W(TIME_W), .FIFO_SIZE_LOG2(FLOG2)
  ) dut (
    .radio_clk     (clk),
    .radio_rst     (rst),
    .radio_rx_data (rx_data),
    .radio_rx_stb  (rx_stb),
    .radio_time    (rx_time),
    .cfg_spp_words (spp),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_num_words (cmd_num),
    .cmd_timed     (cmd_timed),
    .cmd_time      (cmd_time),
    .cmd_stop      (cmd_stop),
    .rx_stream     (rx_stream),
    .running       (running),
    .overrun       (overrun),
    .late          (late)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH_W-1:0]   data;
    logic [TIME_W-1:0] ts;
    logic              last;
    logic              eob;
  } beat_t;

  beat_t capq [NCH][$];
  int    ovr_seen = 0;
  int    late_seen = 0;
  int    vld_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (rx_stream.m_tvalid[c] && rx_stream.m_tready[c]) begin
          beat_t b;
          b.data = rx_stream.m_tdata[c*CH_W +: CH_W];
          b.ts   = rx_stream.m_ttimestamp[c*TIME_W +: TIME_W];
          b.last = rx_stream.m_tlast[c];
          b.eob  = rx_stream.m_teob[c];
          capq[c].push_back(b);
        end
      end
      if (overrun) ovr_seen++;
      if (late) late_seen++;
      if (|rx_stream.m_tvalid) vld_seen++;
    end
  end

  function automatic logic [CH_W-1:0] chan_val(input int c, input int idx);
    return {8'(c + 1), 24'(idx), 8'(c + 9), 24'(idx * 3)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_word(input int idx, input longint t);
    rx_stb  = 1'b1;
    rx_time = 64'(t);
    rx_data = {chan_val(1, idx), chan_val(0, idx)};
    tick();
    rx_stb  = 1'b0;
  endtask

  task automatic issue_cmd(input int num, input logic timed, input longint t, input int spp_w);
    cmd_valid = 1'b1;
    cmd_num   = 32'(num);
    cmd_timed = timed;
    cmd_time  = 64'(t);
    spp       = 16'(spp_w);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_stream.m_tready = '1;
    idle(3);
    cmp_cnt++;
    if ({cmd_ready, running, overrun, late} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b expected 1000 (ready,running,overrun,late)", {cmd_ready, running, overrun, late});
    end
    cmp_cnt++;
    if (rx_stream.m_tvalid !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_tvalid: got %b expected 00", rx_stream.m_tvalid);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_immediate_burst();
    int base[NCH];
    logic lat[10];
    logic [TIME_W-1:0] ets;
    logic elast, eeob;
    beat_t b;
    for (int c = 0; c < NCH; c++) base[c] = capq[c].size();
    rx_stream.m_tready = '1;
    issue_cmd(10, 1'b0, 0, 4);
    for (int i = 0; i < 10; i++) begin
      rx_stb  = 1'b1;
      rx_time = 64'(100 + 2 * i);
      rx_data = {chan_val(1, i), chan_val(0, i)};
      @(negedge clk);
      lat[i] = rx_stream.m_tvalid[0];
      @(posedge clk);
      #1;
    end
    rx_stb = 1'b0;
    idle(6);
    cmp_cnt++;
    if ({lat[1], lat[2]} !== 2'b01) begin
      err_cnt++;
      $display("FAIL imm_latency: tvalid at N+1,N+2 got %b expected 01", {lat[1], lat[2]});
    end
    for (int c = 0; c < NCH; c++) begin
      cmp_cnt++;
      if (capq[c].size() - base[c] !== 10) begin
        err_cnt++;
        $display("FAIL imm_count ch%0d: got %0d expected 10", c, capq[c].size() - base[c]);
      end
      for (int i = 0; i < 10 && base[c] + i < capq[c].size(); i++) begin
        b     = capq[c][base[c] + i];
        ets   = 64'(100 + 8 * (i / 4));
        elast = (i % 4 == 3) || (i == 9);
        eeob  = (i == 9);
        cmp_cnt++;
        if ({b.data, b.ts, b.last, b.eob} !== {chan_val(c, i), ets, elast, eeob}) begin
          err_cnt++;
          $display("FAIL imm_beat ch%0d w%0d: got %h/%0d/%b%b expected %h/%0d/%b%b",
                   c, i, b.data, b.ts, b.last, b.eob, chan_val(c, i), ets, elast, eeob);
        end
      end
    end
    cmp_cnt++;
    if ({cmd_ready, running} !== 2'b10) begin
      err_cnt++;
      $display("FAIL imm_idle: got %b expected 10 (ready,running)", {cmd_ready, running});
    end
  endtask

  task automatic test_timed_start();
    int base[NCH];
    int late0;
    beat_t b;
    for (int c = 0; c < NCH; c++) base[c] = capq[c].size();
    late0 = late_seen;
    issue_cmd(4, 1'b1, 1000, 4);
    cmp_cnt++;
    if ({cmd_ready, running} !== 2'b01) begin
      err_cnt++;
      $display("FAIL timed_accept: got %b expected 01 (ready,running)", {cmd_ready, running});
    end
    for (int i = 0; i < 12; i++) drive_word(i, 990 + 2 * i);
    idle(6);
    cmp_cnt++;
    if (late_seen - late0 !== 0) begin
      err_cnt++;
      $display("FAIL timed_late: got %0d pulses expected 0", late_seen - late0);
    end
    for (int c = 0; c < NCH; c++) begin
      cmp_cnt++;
      if (capq[c].size() - base[c] !== 4) begin
        err_cnt++;
        $display("FAIL timed_count ch%0d: got %0d expected 4", c, capq[c].size() - base[c]);
      end
      for (int i = 0; i < 4 && base[c] + i < capq[c].size(); i++) begin
        b = capq[c][base[c] + i];
        cmp_cnt++;
        if ({b.data, b.ts, b.last, b.eob} !== {chan_val(c, i + 5), 64'd1000, i == 3, i == 3}) begin
          err_cnt++;
          $display("FAIL timed_beat ch%0d w%0d: got %h/%0d/%b%b expected %h/1000/%b%b",
                   c, i, b.data, b.ts, b.last, b.eob, chan_val(c, i + 5), i == 3, i == 3);
        end
      end
    end
    cmp_cnt++;
    if (cmd_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL timed_idle: cmd_ready got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_late();
    int late0, vld0;
    late0 = late_seen;
    vld0  = vld_seen;
    issue_cmd(4, 1'b1, 50, 4);
    for (int i = 0; i < 3; i++) drive_word(i, 60 + 2 * i);
    idle(5);
    cmp_cnt++;
    if (late_seen - late0 !== 1) begin
      err_cnt++;
      $display("FAIL late_pulse: got %0d pulses expected 1", late_seen - late0);
    end
    cmp_cnt++;
    if (vld_seen - vld0 !== 0) begin
      err_cnt++;
      $display("FAIL late_tvalid: got %0d valid cycles expected 0", vld_seen - vld0);
    end
    cmp_cnt++;
    if ({cmd_ready, running} !== 2'b10) begin
      err_cnt++;
      $display("FAIL late_idle: got %b expected 10 (ready,running)", {cmd_ready, running});
    end
  endtask

  task automatic test_wait_stop();
    int vld0;
    vld0 = vld_seen;
    issue_cmd(4, 1'b1, 5000, 4);
    for (int i = 0; i < 2; i++) drive_word(i, 4000 + 2 * i);
    idle(2);
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    tick();
    cmp_cnt++;
    if ({cmd_ready, running} !== 2'b10) begin
      err_cnt++;
      $display("FAIL wstop_idle: got %b expected 10 (ready,running)", {cmd_ready, running});
    end
    for (int i = 0; i < 2; i++) drive_word(i, 5000 + 2 * i);
    idle(5);
    cmp_cnt++;
    if (vld_seen - vld0 !== 0) begin
      err_cnt++;
      $display("FAIL wstop_tvalid: got %0d valid cycles expected 0", vld_seen - vld0);
    end
  endtask

  task automatic test_continuous_stop();
    int base[NCH];
    logic [TIME_W-1:0] ets;
    beat_t b;
    for (int c = 0; c < NCH; c++) base[c] = capq[c].size();
    issue_cmd(0, 1'b0, 0, 8);
    for (int i = 0; i < 13; i++) drive_word(i, 2000 + 2 * i);
    idle(3);
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    idle(2);
    for (int i = 13; i < 17; i++) drive_word(i, 2000 + 2 * i);
    idle(6);
    for (int c = 0; c < NCH; c++) begin
      cmp_cnt++;
      if (capq[c].size() - base[c] !== 14) begin
        err_cnt++;
        $display("FAIL stop_count ch%0d: got %0d expected 14", c, capq[c].size() - base[c]);
      end
      for (int i = 0; i < 14 && base[c] + i < capq[c].size(); i++) begin
        b   = capq[c][base[c] + i];
        ets = (i < 8) ? 64'd2000 : 64'd2016;
        cmp_cnt++;
        if ({b.data, b.ts, b.last, b.eob} !== {chan_val(c, i), ets, (i == 7) || (i == 13), i == 13}) begin
          err_cnt++;
          $display("FAIL stop_beat ch%0d w%0d: got %h/%0d/%b%b expected %h/%0d/%b%b",
                   c, i, b.data, b.ts, b.last, b.eob, chan_val(c, i), ets, (i == 7) || (i == 13), i == 13);
        end
      end
    end
    cmp_cnt++;
    if ({cmd_ready, running} !== 2'b10) begin
      err_cnt++;
      $display("FAIL stop_idle: got %b expected 10 (ready,running)", {cmd_ready, running});
    end
  endtask

  task automatic test_overrun();
    int base[NCH];
    int ovr0;
    beat_t b;
    for (int c = 0; c < NCH; c++) base[c] = capq[c].size();
    ovr0 = ovr_seen;
    rx_stream.m_tready = 2'b01;
    issue_cmd(0, 1'b0, 0, 16);
    for (int i = 0; i < 8; i++) drive_word(i, 3000 + 2 * i);
    idle(3);
    cmp_cnt++;
    if (ovr_seen - ovr0 !== 1) begin
      err_cnt++;
      $display("FAIL ovr_pulse: got %0d pulses expected 1", ovr_seen - ovr0);
    end
    cmp_cnt++;
    if ({cmd_ready, running} !== 2'b10) begin
      err_cnt++;
      $display("FAIL ovr_idle: got %b expected 10 (ready,running)", {cmd_ready, running});
    end
    cmp_cnt++;
    if ({rx_stream.m_tvalid[1], rx_stream.m_tdata[CH_W +: CH_W], rx_stream.m_ttimestamp[TIME_W +: TIME_W]}
        !== {1'b1, chan_val(1, 0), 64'd3000}) begin
      err_cnt++;
      $display("FAIL ovr_stall_hold: got %b/%h/%0d expected 1/%h/3000", rx_stream.m_tvalid[1],
               rx_stream.m_tdata[CH_W +: CH_W], rx_stream.m_ttimestamp[TIME_W +: TIME_W], chan_val(1, 0));
    end
    rx_stream.m_tready = 2'b11;
    idle(6);
    for (int c = 0; c < NCH; c++) begin
      cmp_cnt++;
      if (capq[c].size() - base[c] !== 4) begin
        err_cnt++;
        $display("FAIL ovr_count ch%0d: got %0d expected 4", c, capq[c].size() - base[c]);
      end
      for (int i = 0; i < 4 && base[c] + i < capq[c].size(); i++) begin
        b = capq[c][base[c] + i];
        cmp_cnt++;
        if ({b.data, b.ts, b.last, b.eob} !== {chan_val(c, i), 64'd3000, i == 3, i == 3}) begin
          err_cnt++;
          $display("FAIL ovr_beat ch%0d w%0d: got %h/%0d/%b%b expected %h/3000/%b%b",
                   c, i, b.data, b.ts, b.last, b.eob, chan_val(c, i), i == 3, i == 3);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int base[NCH];
    logic [TIME_W-1:0] ets;
    beat_t b;
    rx_stream.m_tready = 2'b00;
    issue_cmd(0, 1'b0, 0, 8);
    for (int i = 0; i < 3; i++) drive_word(i, 4000 + 2 * i);
    idle(3);
    cmp_cnt++;
    if ({rx_stream.m_tvalid, running} !== 3'b111) begin
      err_cnt++;
      $display("FAIL rstmid_queued: got %b expected 111 (tvalid,running)", {rx_stream.m_tvalid, running});
    end
    rst = 1'b1;
    tick();
    cmp_cnt++;
    if ({rx_stream.m_tvalid, cmd_ready, running} !== 4'b0010) begin
      err_cnt++;
      $display("FAIL rstmid_flush: got %b expected 0010 (tvalid,ready,running)",
               {rx_stream.m_tvalid, cmd_ready, running});
    end
    rst = 1'b0;
    rx_stream.m_tready = 2'b11;
    tick();
    for (int c = 0; c < NCH; c++) base[c] = capq[c].size();
    issue_cmd(5, 1'b0, 0, 4);
    for (int i = 0; i < 5; i++) drive_word(20 + i, 6000 + 2 * i);
    idle(6);
    for (int c = 0; c < NCH; c++) begin
      cmp_cnt++;
      if (capq[c].size() - base[c] !== 5) begin
        err_cnt++;
        $display("FAIL rstmid_count ch%0d: got %0d expected 5", c, capq[c].size() - base[c]);
      end
      for (int i = 0; i < 5 && base[c] + i < capq[c].size(); i++) begin
        b   = capq[c][base[c] + i];
        ets = (i < 4) ? 64'd6000 : 64'd6008;
        cmp_cnt++;
        if ({b.data, b.ts, b.last, b.eob} !== {chan_val(c, 20 + i), ets, i >= 3, i == 4}) begin
          err_cnt++;
          $display("FAIL rstmid_beat ch%0d w%0d: got %h/%0d/%b%b expected %h/%0d/%b%b",
                   c, i, b.data, b.ts, b.last, b.eob, chan_val(c, 20 + i), ets, i >= 3, i == 4);
        end
      end
    end
  endtask

  task automatic test_spp_zero();
    int base[NCH];
    logic [TIME_W-1:0] ets;
    beat_t b;
    for (int c = 0; c < NCH; c++) base[c] = capq[c].size();
    issue_cmd(3, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) drive_word(40 + i, 7000 + 2 * i);
    idle(6);
    for (int c = 0; c < NCH; c++) begin
      cmp_cnt++;
      if (capq[c].size() - base[c] !== 3) begin
        err_cnt++;
        $display("FAIL spp0_count ch%0d: got %0d expected 3", c, capq[c].size() - base[c]);
      end
      for (int i = 0; i < 3 && base[c] + i < capq[c].size(); i++) begin
        b   = capq[c][base[c] + i];
        ets = 64'(7000 + 2 * i);
        cmp_cnt++;
        if ({b.data, b.ts, b.last, b.eob} !== {chan_val(c, 40 + i), ets, 1'b1, i == 2}) begin
          err_cnt++;
          $display("FAIL spp0_beat ch%0d w%0d: got %h/%0d/%b%b expected %h/%0d/1%b",
                   c, i, b.data, b.ts, b.last, b.eob, chan_val(c, 40 + i), ets, i == 2);
        end
      end
    end
  endtask

  initial begin
    rx_stream.m_tready = '1;
    test_reset();
    test_immediate_burst();
    test_timed_start();
    test_late();
    test_wait_stop();
    test_continuous_stop();
    test_overrun();
    test_reset_mid_burst();
    test_spp_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/radio_rx_burst_capture.md
Name: radio_rx_burst_capture

Overview:
- Multi-channel, multi-sample-per-cycle RX capture engine for rfnoc_block_radio's radio_clk domain.
- Takes strobed, channel-coherent ADC words from the radio front end and runs immediate or timed capture commands, finite or continuous.
- Chops the stream into SPP-sized packets, each stamped with the time of its first sample, into per-channel AXI-Stream FIFOs.
- Detects late commands and overruns, and terminates the burst cleanly on either.

Parameters:
SAMP_W, 32, bits per complex sample (sc16 = 32)
NSPC, 1, samples per radio_clk word (1, 2, 4)
NUM_CHANNELS, 1, coherent channels sharing one strobe and one control FSM
TIME_W, 64, timestamp width
FIFO_SIZE_LOG2, 5, per-channel FIFO depth = 2**FIFO_SIZE_LOG2 words (min 2)

Ports:
radio_clk  in  1  sole clock
radio_rst  in  1  synchronous, active-high reset
radio_rx_data  in  NUM_CHANNELS*NSPC*SAMP_W  channel c in bits [c*NSPC*SAMP_W +: NSPC*SAMP_W]
radio_rx_stb  in  1  data word valid (all channels)
radio_time  in  TIME_W  time of first sample of current word; advances NSPC per strobe
cfg_spp_words  in  16  words per packet; 0 treated as 1; sampled at command accept
cmd_valid / cmd_ready  in / out  1 / 1  command handshake
cmd_num_words  in  32  burst length in words; 0 = continuous
cmd_timed  in  1  1 = start at cmd_time
cmd_time  in  TIME_W  start time
cmd_stop  in  1  single-cycle stop pulse
m_tdata  out  NUM_CHANNELS*NSPC*SAMP_W  per-channel data
m_ttimestamp  out  NUM_CHANNELS*TIME_W  time of packet's first word (valid on every beat)
m_tlast / m_teob / m_tvalid  out  NUM_CHANNELS each  end of packet / end of burst / valid
m_tready  in  NUM_CHANNELS  per-channel backpressure
running  out  1  FSM in WAIT_TIME or RUNNING
overrun / late  out  1 / 1  single-cycle status pulses

Behaviour:
- Reset values: state IDLE; cmd_ready=1; m_tvalid=0; running, overrun, late = 0; counters cleared; all FIFOs flushed. Reset mid-burst discards all queued data.
- FSM states:
  - IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready, latch cmd fields and cfg_spp_words. cmd_timed=1 -> WAIT_TIME, else -> RUNNING.
  - WAIT_TIME: on first strobe after accept, radio_time > cmd_time -> pulse late, go IDLE, no output. Otherwise capture begins on the first strobed word with radio_time >= cmd_time; that word is written and the FSM enters RUNNING.
  - RUNNING: every strobed word is written to all channel FIFOs.
  - cmd_ready=0 outside IDLE. cmd_stop is ignored in IDLE; in WAIT_TIME it returns to IDLE with no output.
- Packet/burst counters:
  - pkt_cnt counts words in the current packet; tlast=1 when pkt_cnt==spp-1.
  - Finite burst: remaining count; its last word carries tlast=1, teob=1, then FSM -> IDLE.
  - The first word after each tlast latches radio_time as the packet timestamp.
- Stop: cmd_stop in RUNNING sets stop_pend. The next strobed word is written with tlast=teob=1, then FSM -> IDLE. Stop on the same cycle as a finite burst's final word produces one tlast/teob only.
- Overrun: on a strobe in RUNNING, if any channel FIFO has exactly 1 free entry:
  - that word is written to all channels with tlast=teob=1;
  - overrun pulses the next cycle;
  - FSM -> IDLE.
  - The FIFO is never written while full; no partial packets.
- Latency: input register stage, then FIFO (first-word fall-through). Strobe at cycle N -> m_tvalid at N+2 with an empty FIFO and m_tready=1.
- Output: standard AXI-Stream per channel. tdata/tlast/teob/ttimestamp stay stable while tvalid&!tready. Channels drain independently.
- Widths: counters 32/16 bit unsigned. Timestamp compare is unsigned full TIME_W, no wrap handling.

Decomposition:
- Shared package radio_capture_pkg:
  - state enum {IDLE, WAIT_TIME, RUNNING};
  - FIFO entry struct {data, timestamp, last, eob};
  - localparams for counter widths.
- One sub-module, radio_rx_capture_fifo: single-clock FWFT FIFO, parametrised width/depth, exposing free-space count.
- Instantiated NUM_CHANNELS times from a generate loop.

Test Plan:
- Immediate finite burst: NSPC=1, spp=4, num_words=10, strobe every cycle, radio_time from 100 -> packets of 4/4/2 words; timestamps 100/104/108; teob only on word 10.
- Timed start: NSPC=2, cmd_time=1000, radio_time 990 stepping 2 -> first output word has ttimestamp 1000; running high from accept; no late pulse.
- Late command: cmd_time=50 accepted while radio_time=60 -> late pulses once on the first strobe; FSM IDLE; m_tvalid never asserts; cmd_ready returns to 1.
- Continuous + stop: num_words=0, spp=8, stop after 13 words -> 14th word has tlast=teob=1; packets of 8 and 6; then IDLE.
- Overrun: NUM_CHANNELS=2, FIFO_SIZE_LOG2=2, m_tready[1]=0, continuous -> channel 1 gets 4 words, last with tlast=teob=1; overrun pulses once; channel 0 data identical.
- Reset mid-burst: assert radio_rst during RUNNING with 3 words queued -> next cycle m_tvalid=0, cmd_ready=1, running=0; a subsequent burst has correct timestamps.
